decode_scoreboard: RTL
======================

DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

Interface
REQ-001 Parameter NUM_SRC, 3, number of source operands per instruction (1..4).
REQ-002 Parameter DATA_WIDTH, 32, operand width.
REQ-003 Parameter RF_ADDR_WIDTH, 5, register address width; register 0 reads as zero and is never tracked.
REQ-004 Parameter MAX_OUTSTANDING, 4, maximum long-latency writes in flight (1..2^RF_ADDR_WIDTH-1).
REQ-005 Parameter CNT_WIDTH, 32, stall performance counter width.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  in  1  clock; all state updates on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 Decode_Valid  in  1  decode stage holds a valid instruction.
REQ-010 Decode_RsAddr  in  NUM_SRC*RF_ADDR_WIDTH  source addresses; slot i at bits [i*AW +: AW].
REQ-011 Decode_RsUsed  in  NUM_SRC  slot i is read by the instruction.
REQ-012 Decode_RdAddr / Decode_RdWrtEn / Decode_LongOp  in  AW/1/1  destination, write enable, long-latency (mul/div) op.
REQ-013 RF_RsData  in  NUM_SRC*DATA_WIDTH  register file read data per slot.
REQ-014 IDEX_RdAddr / IDEX_WbRdEn / IDEX_LdEn / EX_AluData  in  AW/1/1/DW  EX-stage destination info and ALU result.
REQ-015 EXMem_RdAddr / EXMem_RdWrtEn / Mem_LdEn / EXMem_AluData / Dcache_DataRd  in  AW/1/1/DW/DW  MEM-stage info.
REQ-016 MemWb_RdAddr / MemWb_RdWrtEn / Wb_DataWrt  in  AW/1/DW  WB-stage info.
REQ-017 Long_WbValid / Long_WbRdAddr / Long_WbData  in  1/AW/DW  long-latency unit completion (one per cycle max).
REQ-018 Pipe_Stall  in  1  downstream stall; blocks issue.
REQ-019 DecodeHazard_RsData  out  NUM_SRC*DATA_WIDTH  forwarded operands, same slot packing.
REQ-020 DecodeHazard_StallReq / DecodeHazard_Issue / DecodeHazard_Busy  out  1/1/1  hazard stall, instruction accepted, any write outstanding.
REQ-021 DecodeHazard_StallCnt  out  CNT_WIDTH  cycles with StallReq=1.

Function
REQ-022 Per slot with nonzero address, operand source priority: EX (IDEX_WbRdEn & match) > MEM (EXMem_RdWrtEn & match; Dcache_DataRd if Mem_LdEn else EXMem_AluData) > Long_Wb (Long_WbValid & match) > WB (MemWb_RdWrtEn & match) > RF; address 0 gives 0 regardless of RF_RsData.
REQ-023 Forwarding mux is combinational, zero latency; unused slots still forward but are excluded from hazard checks.
REQ-024 Scoreboard: one pending bit per register 1..2^AW-1 plus outstanding counter of width clog2(MAX_OUTSTANDING+1).
REQ-025 Load-use hazard: any used slot matches IDEX_RdAddr (nonzero) with IDEX_WbRdEn & IDEX_LdEn, evaluated on current-cycle inputs (no registered history).
REQ-026 RAW hazard: any used slot address pending and not completing via Long_WbValid same cycle.
REQ-027 WAW hazard: Decode_RdWrtEn & Rd nonzero & Rd pending and not completing same cycle.
REQ-028 Capacity hazard: Decode_LongOp & counter == MAX_OUTSTANDING & no Long_WbValid same cycle.
REQ-029 StallReq = Decode_Valid & (any hazard of REQ-025..028); 0 when Decode_Valid=0.
REQ-030 Issue = Decode_Valid & ~StallReq & ~Pipe_Stall.
REQ-031 On Issue with Decode_LongOp & Decode_RdWrtEn & Rd nonzero: set pending[Rd], counter +1 next cycle.
REQ-032 On Long_WbValid with pending[Long_WbRdAddr]=1: clear bit, counter -1; completion to non-pending register ignored, no state change.
REQ-033 Simultaneous set and clear of same register: bit ends set, counter unchanged; set/clear of different registers: both applied, counter unchanged.
REQ-034 Busy = (counter != 0), registered-state based.
REQ-035 StallCnt increments by 1 each cycle StallReq=1, saturates at all-ones, never wraps.

Reset
REQ-036 rst=1 on a clock edge clears all pending bits, counter=0, StallCnt=0; Busy=0 next cycle; combinational outputs follow inputs during reset; Long_WbValid during reset ignored; rst mid-operation discards in-flight tracking.

Verification
REQ-037 Load-use: IDEX_LdEn=1, IDEX_RdAddr=5, decode slot0=x5 used -> StallReq=1, Issue=0, StallCnt +1; next cycle IDEX bubble, EXMem match x5 with Mem_LdEn -> RsData slot0 = Dcache_DataRd, StallReq=0.
REQ-038 Long op: issue mul to x7; following add reads x7 -> StallReq=1 each cycle until Long_WbValid x7 = 0x1234, same cycle RsData = 0x1234, Issue=1, Busy=0 next cycle.
REQ-039 Capacity: MAX_OUTSTANDING=4, issue 4 long ops to x1..x4 -> 5th long op stalls; Long_WbValid x1 same cycle -> 5th issues, counter stays 4.
REQ-040 Priority: x3 matches EX, MEM and WB simultaneously -> slot gets EX_AluData; slot address 0 with all stages writing x0 -> 0.
REQ-041 WAW/zero: long op to x9 pending, decode writes x9 -> stall; decode long op to x0 -> no scoreboard change; StallCnt preset near all-ones saturates.

Source files
------------

// File: rtl/decode_scoreboard.sv
// Decode-stage operand forwarding and long-latency write scoreboard.
// Raises a stall on load-use, RAW, WAW and capacity hazards.
module decode_scoreboard #(
  parameter int NUM_SRC         = 3,
  parameter int DATA_WIDTH      = 32,
  parameter int RF_ADDR_WIDTH   = 5,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              Decode_Valid,
  input  logic [NUM_SRC*RF_ADDR_WIDTH-1:0]  Decode_RsAddr,
  input  logic [NUM_SRC-1:0]                Decode_RsUsed,
  input  logic [RF_ADDR_WIDTH-1:0]          Decode_RdAddr,
  input  logic                              Decode_RdWrtEn,
  input  logic                              Decode_LongOp,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]     RF_RsData,
  input  logic [RF_ADDR_WIDTH-1:0]          IDEX_RdAddr,
  input  logic                              IDEX_WbRdEn,
  input  logic                              IDEX_LdEn,
  input  logic [DATA_WIDTH-1:0]             EX_AluData,
  input  logic [RF_ADDR_WIDTH-1:0]          EXMem_RdAddr,
  input  logic                              EXMem_RdWrtEn,
  input  logic                              Mem_LdEn,
  input  logic [DATA_WIDTH-1:0]             EXMem_AluData,
  input  logic [DATA_WIDTH-1:0]             Dcache_DataRd,
  input  logic [RF_ADDR_WIDTH-1:0]          MemWb_RdAddr,
  input  logic                              MemWb_RdWrtEn,
  input  logic [DATA_WIDTH-1:0]             Wb_DataWrt,
  input  logic                              Long_WbValid,
  input  logic [RF_ADDR_WIDTH-1:0]          Long_WbRdAddr,
  input  logic [DATA_WIDTH-1:0]             Long_WbData,
  input  logic                              Pipe_Stall,
  output logic [NUM_SRC*DATA_WIDTH-1:0]     DecodeHazard_RsData,
  output logic                              DecodeHazard_StallReq,
  output logic                              DecodeHazard_Issue,
  output logic                              DecodeHazard_Busy,
  output logic [CNT_WIDTH-1:0]              DecodeHazard_StallCnt
);

  localparam int AW = RF_ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int NR = 2 ** AW;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [NR-1:0]        r_pend;
  logic [OW-1:0]        r_cnt;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  logic w_lu;
  logic w_raw;
  logic w_waw;
  logic w_cap;
  logic w_stall;
  logic w_issue;
  logic w_set;
  logic w_clr;

  always_comb begin
    DecodeHazard_RsData = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (Decode_RsAddr[i*AW +: AW] == '0)
        DecodeHazard_RsData[i*DW +: DW] = '0;
      else if (IDEX_WbRdEn &&
               IDEX_RdAddr == Decode_RsAddr[i*AW +: AW])
        DecodeHazard_RsData[i*DW +: DW] = EX_AluData;
      else if (EXMem_RdWrtEn &&
               EXMem_RdAddr == Decode_RsAddr[i*AW +: AW])
        DecodeHazard_RsData[i*DW +: DW] =
          Mem_LdEn ? Dcache_DataRd : EXMem_AluData;
      else if (Long_WbValid &&
               Long_WbRdAddr == Decode_RsAddr[i*AW +: AW])
        DecodeHazard_RsData[i*DW +: DW] = Long_WbData;
      else if (MemWb_RdWrtEn &&
               MemWb_RdAddr == Decode_RsAddr[i*AW +: AW])
        DecodeHazard_RsData[i*DW +: DW] = Wb_DataWrt;
      else
        DecodeHazard_RsData[i*DW +: DW] = RF_RsData[i*DW +: DW];
    end
  end

  // A register completing this cycle no longer blocks its readers.
  always_comb begin
    w_lu  = 1'b0;
    w_raw = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (Decode_RsUsed[i] && Decode_RsAddr[i*AW +: AW] != '0) begin
        if (IDEX_WbRdEn && IDEX_LdEn &&
            IDEX_RdAddr == Decode_RsAddr[i*AW +: AW])
          w_lu = 1'b1;
        if (r_pend[Decode_RsAddr[i*AW +: AW]] &&
            !(Long_WbValid &&
              Long_WbRdAddr == Decode_RsAddr[i*AW +: AW]))
          w_raw = 1'b1;
      end
    end
  end

  assign w_waw = Decode_RdWrtEn && Decode_RdAddr != '0 &&
                 r_pend[Decode_RdAddr] &&
                 !(Long_WbValid && Long_WbRdAddr == Decode_RdAddr);

  assign w_cap = Decode_LongOp && !Long_WbValid &&
                 r_cnt == OW'(MAX_OUTSTANDING);

  assign w_stall = Decode_Valid && (w_lu || w_raw || w_waw || w_cap);
  assign w_issue = Decode_Valid && !w_stall && !Pipe_Stall;

  assign w_set = w_issue && Decode_LongOp && Decode_RdWrtEn &&
                 Decode_RdAddr != '0;
  assign w_clr = Long_WbValid && r_pend[Long_WbRdAddr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= '0;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      // Set is applied after clear so a same-register pair stays pending.
      if (w_clr)
        r_pend[Long_WbRdAddr] <= 1'b0;
      if (w_set)
        r_pend[Decode_RdAddr] <= 1'b1;
      if (w_set && !w_clr)
        r_cnt <= r_cnt + OW'(1);
      else if (w_clr && !w_set)
        r_cnt <= r_cnt - OW'(1);
      if (w_stall && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
    end
  end

  assign DecodeHazard_StallReq = w_stall;
  assign DecodeHazard_Issue    = w_issue;
  assign DecodeHazard_Busy     = (r_cnt != '0);
  assign DecodeHazard_StallCnt = r_stall_cnt;

endmodule
